// File: rtl/sram_pkg.sv
// Shared types and helpers for the banked SRAM wrapper: FSM states, bank-select width,
// and expansion of a per-slice write mask to a per-bit mask.
package sram_pkg;

   localparam int MAX_DW = 1024;
   localparam int MAX_MW = 128;
   localparam int DW_IDX = $clog2(MAX_DW);
   localparam int MW_IDX = $clog2(MAX_MW);

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } state_t;

   function automatic int bank_sel_w(input int num_banks);
      return $clog2(num_banks);
   endfunction

   // Every mask bit covers dw/mw contiguous data bits, LSB slice first.
   function automatic logic [MAX_DW-1:0] expand_mask(input logic [MAX_MW-1:0] wmask,
                                                      input int dw,
                                                      input int mw);
      logic [MAX_DW-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_DW; i++) begin
         if (i < dw) begin
            m[DW_IDX'(i)] = wmask[MW_IDX'(i / (dw / mw))];
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/sram_banked_rmw_if.sv
// Request/response port between the memory-controller side and the banked SRAM wrapper.
interface sram_banked_rmw_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 10,
   parameter int WMASK_WIDTH = 4
);
   logic                   csb0;
   logic                   web0;
   logic [ADDR_WIDTH-1:0]  addr0;
   logic [DATA_WIDTH-1:0]  din0;
   logic [WMASK_WIDTH-1:0] wmask0;
   logic                   ready0;
   logic [DATA_WIDTH-1:0]  dout0;
   logic                   dout_valid0;

   modport master (
      output csb0, web0, addr0, din0, wmask0,
      input  ready0, dout0, dout_valid0
   );

   modport slave (
      input  csb0, web0, addr0, din0, wmask0,
      output ready0, dout0, dout_valid0
   );
endinterface

// File: rtl/sram_1bank.sv
// Single-port synchronous SRAM macro model: write or read on posedge, read data registered
// and held until the next read.
module sram_1bank #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk0,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk0) begin
      if (!csb0) begin
         if (!web0) begin
            mem[addr0] <= din0;
         end else begin
            dout0 <= mem[addr0];
         end
      end
   end

endmodule

// File: rtl/sram_bank_dec.sv
// One-hot chip-select / write-enable fan-out; every bank is idle (csb=1, web=1) unless enabled.
module sram_bank_dec
   import sram_pkg::*;
#(
   parameter  int NUM_BANKS = 4,
   localparam int BANK_SEL  = bank_sel_w(NUM_BANKS)
) (
   input  logic                 en,
   input  logic                 wr,
   input  logic [BANK_SEL-1:0]  sel,
   output logic [NUM_BANKS-1:0] csb,
   output logic [NUM_BANKS-1:0] web
);

   always_comb begin
      csb = '1;
      web = '1;
      if (en) begin
         csb[sel] = 1'b0;
         web[sel] = ~wr;
      end
   end

endmodule

// File: rtl/sram_banked_rmw.sv
// Banked SRAM wrapper with per-slice write masking; partial writes become a bank read
// followed by a merged write, stalling the requester for one cycle.
//
// state  | meaning
// IDLE   | accepting requests; reads, full writes and zero-mask writes complete here
// RMW_WR | writing merged data for the partial write captured in IDLE; ready0 low
module sram_banked_rmw
   import sram_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 10,
   parameter int NUM_BANKS   = 4,
   parameter int WMASK_WIDTH = 4,
   parameter int OUT_REG     = 0
) (
   input  logic               clk0,
   input  logic               rst0_n,
   sram_banked_rmw_if.slave   bus
);

   localparam int BANK_SEL = bank_sel_w(NUM_BANKS);
   localparam int BANK_AW  = ADDR_WIDTH - BANK_SEL;

   state_t                 state;
   state_t                 state_nxt;
   logic                   alive;

   logic [BANK_SEL-1:0]    hold_bank;
   logic [BANK_AW-1:0]     hold_addr;
   logic [DATA_WIDTH-1:0]  hold_din;
   logic [WMASK_WIDTH-1:0] hold_wmask;

   logic                   rd_pend;
   logic [BANK_SEL-1:0]    rd_bank;
   logic [DATA_WIDTH-1:0]  rd_data;
   logic [DATA_WIDTH-1:0]  dout_q;

   logic                   acc;
   logic                   req_rd;
   logic                   req_full;
   logic                   req_part;
   logic [BANK_SEL-1:0]    req_bank;
   logic [BANK_AW-1:0]     req_addr;

   logic                   bank_en;
   logic                   bank_wr;
   logic [BANK_SEL-1:0]    bank_idx;
   logic [BANK_AW-1:0]     bank_addr;
   logic [DATA_WIDTH-1:0]  bank_din;
   logic [NUM_BANKS-1:0]   bank_csb;
   logic [NUM_BANKS-1:0]   bank_web;
   logic [DATA_WIDTH-1:0]  bank_dout [NUM_BANKS];

   logic [MAX_DW-1:0]      mask_full;
   logic [DATA_WIDTH-1:0]  mask_e;
   logic [DATA_WIDTH-1:0]  merged;
   logic                   unused_mask;

   // ready0 stays low through reset and until the first edge after release
   assign bus.ready0 = alive && (state == IDLE);

   assign req_bank = bus.addr0[ADDR_WIDTH-1 -: BANK_SEL];
   assign req_addr = bus.addr0[BANK_AW-1:0];
   assign acc      = !bus.csb0 && bus.ready0;
   assign req_rd   = acc && bus.web0;
   assign req_full = acc && !bus.web0 && (&bus.wmask0);
   assign req_part = acc && !bus.web0 && (|bus.wmask0) && !(&bus.wmask0);

   assign mask_full   = expand_mask(MAX_MW'(hold_wmask), DATA_WIDTH, WMASK_WIDTH);
   assign mask_e      = mask_full[DATA_WIDTH-1:0];
   assign unused_mask = ^mask_full[MAX_DW-1:DATA_WIDTH];
   assign merged      = (bank_dout[hold_bank] & ~mask_e) | (hold_din & mask_e);
   assign rd_data     = bank_dout[rd_bank];

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         state <= IDLE;
         alive <= 1'b0;
      end else begin
         state <= state_nxt;
         alive <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      bank_en   = 1'b0;
      bank_wr   = 1'b0;
      bank_idx  = req_bank;
      bank_addr = req_addr;
      bank_din  = bus.din0;
      case (state)
         IDLE: begin
            if (req_rd) begin
               bank_en = 1'b1;
            end else if (req_full) begin
               bank_en = 1'b1;
               bank_wr = 1'b1;
            end else if (req_part) begin
               bank_en   = 1'b1;
               state_nxt = RMW_WR;
            end
         end
         RMW_WR: begin
            bank_en   = 1'b1;
            bank_wr   = 1'b1;
            bank_idx  = hold_bank;
            bank_addr = hold_addr;
            bank_din  = merged;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         hold_bank  <= '0;
         hold_addr  <= '0;
         hold_din   <= '0;
         hold_wmask <= '0;
         rd_pend    <= 1'b0;
         rd_bank    <= '0;
         dout_q     <= '0;
      end else begin
         if (req_part) begin
            hold_bank  <= req_bank;
            hold_addr  <= req_addr;
            hold_din   <= bus.din0;
            hold_wmask <= bus.wmask0;
         end
         rd_pend <= req_rd;
         if (req_rd) begin
            rd_bank <= req_bank;
         end
         if (rd_pend) begin
            dout_q <= rd_data;
         end
      end
   end

   // dout_q keeps the last returned word so dout0 holds across RMW bank reads
   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic valid_q;
         always_ff @(posedge clk0 or negedge rst0_n) begin
            if (!rst0_n) begin
               valid_q <= 1'b0;
            end else begin
               valid_q <= rd_pend;
            end
         end
         assign bus.dout0       = dout_q;
         assign bus.dout_valid0 = valid_q;
      end else begin : g_out_comb
         assign bus.dout0       = rd_pend ? rd_data : dout_q;
         assign bus.dout_valid0 = rd_pend;
      end
   endgenerate

   sram_bank_dec #(
      .NUM_BANKS (NUM_BANKS)
   ) u_dec (
      .en  (bank_en),
      .wr  (bank_wr),
      .sel (bank_idx),
      .csb (bank_csb),
      .web (bank_web)
   );

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      sram_1bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (BANK_AW)
      ) u_bank (
         .clk0  (clk0),
         .csb0  (bank_csb[b]),
         .web0  (bank_web[b]),
         .addr0 (bank_addr),
         .din0  (bank_din),
         .dout0 (bank_dout[b])
      );
   end

endmodule
